up_down_counter_mod: RTL and testbench
======================================

// Module: up_down_counter_mod
// PURPOSE
//  Parametrised up/down counter with programmable modulus, step, wrap or saturate mode,
//  synchronous parallel load, terminal-count pulse and sticky overflow/underflow flags.
//  Next-generation general counter for timers, address generators and event tallies.
//  Drop-in for the fixed 5-bit up/down counter when load/flags are tied off.
// PARAMETERS
//  WIDTH     5             counter width in bits
//  MAX_VAL   2**WIDTH-1    highest legal count; count range is 0..MAX_VAL (modulus MAX_VAL+1)
//  STEP      1             increment/decrement per enabled cycle; 1 <= STEP <= MAX_VAL
//  SATURATE  0             0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL
//  RESET_VAL 0             count value after reset; must be <= MAX_VAL
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  en           in   1      count enable
//  ctrl         in   1      direction: 0 = up, 1 = down
//  load         in   1      synchronous parallel load strobe
//  load_val     in   WIDTH  value to load
//  clr_flags    in   1      clears ovf_sticky/unf_sticky
//  counter_out  out  WIDTH  registered count
//  tc           out  1      registered one-cycle terminal-count pulse
//  ovf_sticky   out  1      set by up-direction wrap/clamp; held until clr_flags/reset
//  unf_sticky   out  1      set by down-direction wrap/clamp; held until clr_flags/reset
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all outputs registered, 1-cycle latency.
//  - Priority per edge: reset > load > en. ctrl is ignored when en=0 or load=1.
//  - reset=1: counter_out=RESET_VAL, tc=0, ovf_sticky=0, unf_sticky=0.
//  - load=1: counter_out = (load_val > MAX_VAL) ? MAX_VAL : load_val; tc=0; flags unchanged
//    except clr_flags still applies.
//  - en=0 (no load): counter_out holds; tc=0.
//  - Up (en=1, ctrl=0): sum computed in WIDTH+1 bits, no truncation before compare.
//    sum <= MAX_VAL: counter_out=sum, tc=0.
//    sum > MAX_VAL: wrap -> counter_out=sum-(MAX_VAL+1); saturate -> counter_out=MAX_VAL;
//    both: tc=1 next cycle, ovf_sticky=1.
//  - Down (en=1, ctrl=1): counter_out >= STEP: counter_out-STEP, tc=0.
//    counter_out < STEP: wrap -> counter_out+(MAX_VAL+1)-STEP; saturate -> 0;
//    both: tc=1, unf_sticky=1.
//  - Saturate mode held at limit with en=1 toward it: every such cycle is a clamp event:
//    tc=1 each cycle, flag stays set, count unchanged.
//  - clr_flags and a same-cycle new event: set wins (flag reads 1 next cycle).
//  - Reset mid-count overrides everything that cycle; counting resumes from RESET_VAL the
//    cycle after reset deasserts if en=1.
//  - Direction change takes effect on the same edge ctrl is sampled; no dead cycle.
//  - Out-of-range parameters (STEP=0, STEP>MAX_VAL, MAX_VAL>=2**WIDTH, RESET_VAL>MAX_VAL)
//    are illegal; elaboration-time check stops simulation with an error.
// TESTING (WIDTH=5, MAX_VAL=23, RESET_VAL=0 unless stated)
//  1 Wrap up, STEP=1: load 22, en=1 ctrl=0 three cycles -> 23, 0 (tc=1, ovf_sticky=1), 1 (tc=0).
//  2 Wrap down, STEP=1: from reset, en=1 ctrl=1 -> 23 with tc=1, unf_sticky=1; next 22, tc=0.
//  3 Saturate, STEP=4: load 21, count up -> 23 (tc=1, ovf=1); hold en -> 23 with tc=1 each cycle;
//    ctrl=1 -> 19, tc=0.
//  4 Load clamp/priority: load=1, load_val=30, en=1 -> 23; load and reset same cycle -> 0.
//  5 Flags: ovf_sticky=1, assert clr_flags alone -> 0; clr_flags in same cycle as new wrap -> 1.
//  6 Reset mid-count: count to 10, reset=1 one cycle -> 0, tc/flags 0; en=1 after -> 1, 2, 3.

Source files
------------

// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter: modulus, step, wrap/saturate, load,
// terminal-count pulse and sticky overflow/underflow flags.
module up_down_counter_mod #(
   parameter int WIDTH     = 5,
   parameter int MAX_VAL   = 2**WIDTH-1,
   parameter int STEP      = 1,
   parameter bit SATURATE  = 1'b0,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             ctrl,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] counter_out,
   output logic             tc,
   output logic             ovf_sticky,
   output logic             unf_sticky
);

   if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL >= 2**WIDTH ||
       STEP < 1 || STEP > MAX_VAL ||
       RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_param_err
      $error("up_down_counter_mod: illegal parameter set");
   end

   // Arithmetic is done one bit wider so no carry/borrow is lost before compare.
   localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MAX_VAL + 1);
   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH:0]   cnt_w;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   load_w;
   logic             up_ovf;
   logic             dn_unf;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] dn_val;
   logic [WIDTH-1:0] ld_val;

   always_comb begin
      cnt_w  = {1'b0, cnt_q};
      sum_w  = cnt_w + STEP_W;
      load_w = {1'b0, load_val};
      up_ovf = sum_w > MAX_W;
      dn_unf = cnt_w < STEP_W;

      if (!up_ovf)
         up_val = WIDTH'(sum_w);
      else if (SATURATE)
         up_val = WIDTH'(MAX_W);
      else
         up_val = WIDTH'(sum_w - MOD_W);

      if (!dn_unf)
         dn_val = WIDTH'(cnt_w - STEP_W);
      else if (SATURATE)
         dn_val = '0;
      else
         dn_val = WIDTH'(cnt_w + MOD_W - STEP_W);

      ld_val = (load_w > MAX_W) ? WIDTH'(MAX_W) : load_val;
   end

   // A new wrap/clamp event in the same cycle as clr_flags leaves the flag set.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q & ~clr_flags;
      unf_d = unf_q & ~clr_flags;
      if (reset) begin
         cnt_d = RST_W;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (load) begin
         cnt_d = ld_val;
      end else if (en && !ctrl) begin
         cnt_d = up_val;
         if (up_ovf) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
         end
      end else if (en && ctrl) begin
         cnt_d = dn_val;
         if (dn_unf) begin
            tc_d  = 1'b1;
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
   end

   assign counter_out = cnt_q;
   assign tc          = tc_q;
   assign ovf_sticky  = ovf_q;
   assign unf_sticky  = unf_q;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod: vector table, hand sequences and
// randomized run against a behavioural model (MAX_VAL=23).
module tb_up_down_counter_mod;

   localparam int MAXV = 23;

   logic       clk = 1'b0;
   logic       reset, en, ctrl, load, clr_flags;
   logic [4:0] load_val;
   logic [4:0] cnt_a, cnt_b;
   logic       tc_a, ovf_a, unf_a;
   logic       tc_b, ovf_b, unf_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   up_down_counter_mod #(
      .WIDTH(5), .MAX_VAL(MAXV), .STEP(1), .SATURATE(1'b0), .RESET_VAL(0)
   ) u_wrap (
      .clk(clk), .reset(reset), .en(en), .ctrl(ctrl), .load(load),
      .load_val(load_val), .clr_flags(clr_flags), .counter_out(cnt_a),
      .tc(tc_a), .ovf_sticky(ovf_a), .unf_sticky(unf_a)
   );

   up_down_counter_mod #(
      .WIDTH(5), .MAX_VAL(MAXV), .STEP(4), .SATURATE(1'b1), .RESET_VAL(0)
   ) u_sat (
      .clk(clk), .reset(reset), .en(en), .ctrl(ctrl), .load(load),
      .load_val(load_val), .clr_flags(clr_flags), .counter_out(cnt_b),
      .tc(tc_b), .ovf_sticky(ovf_b), .unf_sticky(unf_b)
   );

   typedef struct {
      int cnt;
      bit tc;
      bit ovf;
      bit unf;
   } ms_t;

   typedef struct {
      bit rst, en, ctrl, ld;
      int lv;
      bit clr;
      int cnt;
      bit tc, ovf, unf;
   } vec_t;

   ms_t  ma, mb;
   vec_t tbl[$];

   // Reference: counter as an integer in 0..MAXV, events judged by plain arithmetic.
   function automatic ms_t mstep(ms_t s, int stp, bit sat, bit rst, bit e,
                                 bit dn, bit ld, int lv, bit clr);
      ms_t n = s;
      n.tc = 0;
      if (rst) begin
         n.cnt = 0; n.ovf = 0; n.unf = 0;
         return n;
      end
      if (clr) begin
         n.ovf = 0; n.unf = 0;
      end
      if (ld) begin
         n.cnt = (lv > MAXV) ? MAXV : lv;
      end else if (e && !dn) begin
         if (s.cnt + stp > MAXV) begin
            n.cnt = sat ? MAXV : s.cnt + stp - (MAXV + 1);
            n.tc = 1; n.ovf = 1;
         end else n.cnt = s.cnt + stp;
      end else if (e) begin
         if (s.cnt - stp < 0) begin
            n.cnt = sat ? 0 : s.cnt - stp + (MAXV + 1);
            n.tc = 1; n.unf = 1;
         end else n.cnt = s.cnt - stp;
      end
      return n;
   endfunction

   function automatic vec_t mk(bit r, bit e, bit c, bit l, int lv, bit cl,
                               int cnt, bit t, bit o, bit u);
      vec_t v;
      v.rst = r; v.en = e; v.ctrl = c; v.ld = l; v.lv = lv; v.clr = cl;
      v.cnt = cnt; v.tc = t; v.ovf = o; v.unf = u;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(bit r, bit e, bit c, bit l, int lv, bit cl);
      reset = r; en = e; ctrl = c; load = l; load_val = 5'(lv); clr_flags = cl;
      @(posedge clk);
      ma = mstep(ma, 1, 1'b0, r, e, c, l, lv, cl);
      mb = mstep(mb, 4, 1'b1, r, e, c, l, lv, cl);
      #1;
   endtask

   task automatic chk_b(string tag, int c, bit t, bit o, bit u);
      chk({tag, ".cnt"}, int'(cnt_b), c);
      chk({tag, ".tc"},  int'(tc_b), int'(t));
      chk({tag, ".ovf"}, int'(ovf_b), int'(o));
      chk({tag, ".unf"}, int'(unf_b), int'(u));
   endtask

   initial begin
      reset = 1; en = 0; ctrl = 0; load = 0; load_val = '0; clr_flags = 0;
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};

      //                 rst en ct ld lv  clr cnt tc ovf unf
      tbl.push_back(mk(1, 0, 0, 0, 0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0,  0, 23, 1, 0, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0,  0, 22, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 22, 0, 22, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0, 23, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0,  0, 1, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0,  1, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0,  1,  1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 23, 0, 23, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,  1,  0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 1, 30, 0, 23, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 1, 5,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 9,  0,  9, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0, 10, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0,  1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0,  2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0,  3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0,  0,  3, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0,  0,  2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,  0,  3, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v = tbl[i];
         apply(v.rst, v.en, v.ctrl, v.ld, v.lv, v.clr);
         chk($sformatf("vec%0d.cnt", i), int'(cnt_a), v.cnt);
         chk($sformatf("vec%0d.tc", i),  int'(tc_a),  int'(v.tc));
         chk($sformatf("vec%0d.ovf", i), int'(ovf_a), int'(v.ovf));
         chk($sformatf("vec%0d.unf", i), int'(unf_a), int'(v.unf));
      end

      // Saturating instance, STEP=4: clamp at both limits, held at limit.
      apply(1, 0, 0, 0, 0, 0);   chk_b("sat_rst", 0, 0, 0, 0);
      apply(0, 0, 0, 1, 21, 0);  chk_b("sat_ld", 21, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0);   chk_b("sat_up0", 23, 1, 1, 0);
      apply(0, 1, 0, 0, 0, 0);   chk_b("sat_up1", 23, 1, 1, 0);
      apply(0, 1, 0, 0, 0, 0);   chk_b("sat_up2", 23, 1, 1, 0);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_dn0", 19, 0, 1, 0);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_dn1", 15, 0, 1, 0);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_dn2", 11, 0, 1, 0);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_dn3", 7, 0, 1, 0);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_dn4", 3, 0, 1, 0);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_lo0", 0, 1, 1, 1);
      apply(0, 1, 1, 0, 0, 0);   chk_b("sat_lo1", 0, 1, 1, 1);
      apply(0, 0, 0, 0, 0, 1);   chk_b("sat_clr", 0, 0, 0, 0);

      // Randomized traffic on both instances against the model.
      apply(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         bit r  = ($urandom_range(0, 39) == 0);
         bit e  = ($urandom_range(0, 3) != 0);
         bit c  = $urandom_range(0, 1) != 0;
         bit l  = ($urandom_range(0, 7) == 0);
         int lv = $urandom_range(0, 31);
         bit cl = ($urandom_range(0, 9) == 0);
         apply(r, e, c, l, lv, cl);
         chk($sformatf("rnd%0d.a.cnt", i), int'(cnt_a), ma.cnt);
         chk($sformatf("rnd%0d.a.tc", i),  int'(tc_a),  int'(ma.tc));
         chk($sformatf("rnd%0d.a.ovf", i), int'(ovf_a), int'(ma.ovf));
         chk($sformatf("rnd%0d.a.unf", i), int'(unf_a), int'(ma.unf));
         chk($sformatf("rnd%0d.b.cnt", i), int'(cnt_b), mb.cnt);
         chk($sformatf("rnd%0d.b.tc", i),  int'(tc_b),  int'(mb.tc));
         chk($sformatf("rnd%0d.b.ovf", i), int'(ovf_b), int'(mb.ovf));
         chk($sformatf("rnd%0d.b.unf", i), int'(unf_b), int'(mb.unf));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
